// File: rtl/ctrl_pkg.sv
// Shared types and constants for the sequencing control unit: FSM state
// encoding, opcode map and the opcode-width legality check.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } ctrl_state_t;

    localparam logic [3:0] OP_ALU = 4'd0;
    localparam logic [3:0] OP_CMP = 4'd1;
    localparam logic [3:0] OP_LD  = 4'd2;
    localparam logic [3:0] OP_ST  = 4'd3;
    localparam logic [3:0] OP_IN  = 4'd4;
    localparam logic [3:0] OP_OUT = 4'd5;
    localparam logic [3:0] OP_J   = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;

    function automatic bit opcode_w_legal(input int w);
        return (w == 3) || (w == 4);
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode classifier: registered opcode -> one-hot class bits.
// Codes 8..15 (reachable only with a 4-bit opcode) classify as illegal.
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 3
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output logic                o_is_alu,
    output logic                o_is_mem_rd,
    output logic                o_is_mem_wr,
    output logic                o_is_io_in,
    output logic                o_is_io_out,
    output logic                o_is_jmp,
    output logic                o_is_jc,
    output logic                o_is_cmp,
    output logic                o_is_illegal
);

    logic [3:0] w_op4;

    if (OPCODE_W == 4) begin : g_w4
        assign w_op4 = i_opcode;
    end else begin : g_w3
        assign w_op4 = {1'b0, i_opcode};
    end

    always_comb begin
        o_is_alu     = 1'b0;
        o_is_mem_rd  = 1'b0;
        o_is_mem_wr  = 1'b0;
        o_is_io_in   = 1'b0;
        o_is_io_out  = 1'b0;
        o_is_jmp     = 1'b0;
        o_is_jc      = 1'b0;
        o_is_cmp     = 1'b0;
        o_is_illegal = 1'b0;
        case (w_op4)
            OP_ALU:  o_is_alu    = 1'b1;
            OP_CMP:  o_is_cmp    = 1'b1;
            OP_LD:   o_is_mem_rd = 1'b1;
            OP_ST:   o_is_mem_wr = 1'b1;
            OP_IN:   o_is_io_in  = 1'b1;
            OP_OUT:  o_is_io_out = 1'b1;
            OP_J:    o_is_jmp    = 1'b1;
            OP_JC:   o_is_jc     = 1'b1;
            default: o_is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer driving the datapath strobes.
// Build option CTRL_ILLEGAL_TRAP_EN: unassigned opcodes halt instead of NOP.
module seq_control_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                instr_ack,
    input  logic                flag_neq,
    input  logic                mem_ready,
    input  logic                io_ready,
    output logic                J,
    output logic                JC,
    output logic                INA,
    output logic                RM,
    output logic                WM,
    output logic                SIN,
    output logic                SOUT,
    output logic                WR,
    output logic                NEQ,
    output logic                pc_inc,
    output logic                busy,
    output logic                halted
);

    if (!opcode_w_legal(OPCODE_W)) begin : g_bad_opcode_w
        $error("seq_control_unit: OPCODE_W must be 3 or 4");
    end

    ctrl_state_t         r_state;
    ctrl_state_t         w_next;
    logic [OPCODE_W-1:0] r_opcode;
    logic w_is_alu, w_is_mem_rd, w_is_mem_wr, w_is_io_in, w_is_io_out;
    logic w_is_jmp, w_is_jc, w_is_cmp, w_is_illegal;

    ctrl_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
        .i_opcode     (r_opcode),
        .o_is_alu     (w_is_alu),
        .o_is_mem_rd  (w_is_mem_rd),
        .o_is_mem_wr  (w_is_mem_wr),
        .o_is_io_in   (w_is_io_in),
        .o_is_io_out  (w_is_io_out),
        .o_is_jmp     (w_is_jmp),
        .o_is_jc      (w_is_jc),
        .o_is_cmp     (w_is_cmp),
        .o_is_illegal (w_is_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_FETCH;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_FETCH && instr_valid)
                r_opcode <= opcode;
        end
    end

    always_comb begin
        w_next    = r_state;
        instr_ack = 1'b0;
        J         = 1'b0;
        JC        = 1'b0;
        INA       = 1'b0;
        RM        = 1'b0;
        WM        = 1'b0;
        SIN       = 1'b0;
        SOUT      = 1'b0;
        WR        = 1'b0;
        NEQ       = 1'b0;
        pc_inc    = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                instr_ack = 1'b1;
                if (instr_valid) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                busy   = 1'b1;
                w_next = ST_EXEC;
            end
            ST_EXEC: begin
                busy   = 1'b1;
                w_next = ST_FETCH;
                // Memory/I-O classes hold their strobe in EXEC until the matching ready.
                if (w_is_alu) begin
                    INA    = 1'b1;
                    w_next = ST_WB;
                end else if (w_is_cmp) begin
                    NEQ    = 1'b1;
                    pc_inc = 1'b1;
                end else if (w_is_jmp) begin
                    J = 1'b1;
                end else if (w_is_jc) begin
                    JC     = flag_neq;
                    pc_inc = !flag_neq;
                end else if (w_is_mem_rd) begin
                    RM     = 1'b1;
                    w_next = mem_ready ? ST_WB : ST_EXEC;
                end else if (w_is_io_in) begin
                    SIN    = 1'b1;
                    w_next = io_ready ? ST_WB : ST_EXEC;
                end else if (w_is_mem_wr) begin
                    WM     = 1'b1;
                    pc_inc = mem_ready;
                    w_next = mem_ready ? ST_FETCH : ST_EXEC;
                end else if (w_is_io_out) begin
                    SOUT   = 1'b1;
                    pc_inc = io_ready;
                    w_next = io_ready ? ST_FETCH : ST_EXEC;
                end else if (w_is_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    w_next = ST_HALT;
`else
                    pc_inc = 1'b1;
`endif
                end
            end
            ST_WB: begin
                busy   = 1'b1;
                WR     = 1'b1;
                pc_inc = 1'b1;
                w_next = ST_FETCH;
            end
            ST_HALT: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                halted = 1'b1;
`else
                w_next = ST_FETCH;
`endif
            end
            default: w_next = ST_FETCH;
        endcase
    end

endmodule
